// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake, optional two-entry skid buffer,
// flush, and bubble insertion that clears the control field but keeps the data field.
module id_ex_pipe_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 138,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [1:0]        occ_q, occ_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic              rdy_q, rdy_d;
    logic              in_acc, out_take;

    assign out_valid = (occ_q != 2'd0);
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign occupancy = occ_q;

    // With the skid buffer, in_ready comes straight from a flop so the decoder
    // never sees a combinational path from out_ready.
    assign in_ready = (SKID != 0) ? rdy_q : (!out_valid || out_ready);

    assign in_acc   = in_valid && in_ready;
    assign out_take = out_valid && out_ready;

    always_comb begin
        occ_d    = occ_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush) begin
            occ_d    = 2'd0;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (in_acc) begin
                        occ_d    = 2'd1;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                2'd1: begin
                    if (in_acc && out_take) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (in_acc) begin
                        occ_d    = 2'd2;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (out_take) begin
                        occ_d    = 2'd0;
                        m_ctrl_d = '0;
                    end
                end
                2'd2: begin
                    if (out_take) begin
                        occ_d    = 2'd1;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = '0;
                    end
                end
                default: begin
                    occ_d    = 2'd0;
                    m_ctrl_d = '0;
                end
            endcase
        end
        rdy_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q    <= 2'd0;
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
            rdy_q    <= 1'b1;
        end else begin
            occ_q    <= occ_d;
            m_ctrl_q <= m_ctrl_d;
            m_data_q <= m_data_d;
            s_ctrl_q <= s_ctrl_d;
            s_data_q <= s_data_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a SKID=1 and a SKID=0 instance share stimulus and are
// each compared every cycle against a small FIFO reference model.
module tb_id_ex_pipe_reg;

    localparam int CW = 12;
    localparam int DW = 138;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready [2];
    logic          out_valid[2];
    logic [CW-1:0] out_ctrl [2];
    logic [DW-1:0] out_data [2];
    logic [1:0]    occupancy[2];

    int tests = 0;
    int fails = 0;

    // reference model: per instance a tiny FIFO, its capacity, and the last shown data
    ent_t          fifo[2][2];
    int            sz[2];
    int            cap[2];
    logic [DW-1:0] last_d[2];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_ctrl(out_ctrl[0]),
        .out_data(out_data[0]), .occupancy(occupancy[0])
    );

    id_ex_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_ctrl(out_ctrl[1]),
        .out_data(out_data[1]), .occupancy(occupancy[1])
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // SKID=1 accepts whenever it holds fewer than two entries; SKID=0 accepts when
    // empty or when its single entry leaves on this same edge.
    function automatic logic exp_ready(input int k);
        if (k == 0) return (sz[0] < 2);
        return (sz[1] == 0) || out_ready;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s%0d_out_valid", 1 - k), out_valid[k], sz[k] > 0);
            chk($sformatf("s%0d_out_ctrl", 1 - k), out_ctrl[k], (sz[k] > 0) ? fifo[k][0].c : '0);
            chk($sformatf("s%0d_out_data", 1 - k), out_data[k], (sz[k] > 0) ? fifo[k][0].d : last_d[k]);
            chk($sformatf("s%0d_occupancy", 1 - k), occupancy[k], sz[k]);
            chk($sformatf("s%0d_in_ready", 1 - k), in_ready[k], exp_ready(k));
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic push, pop;
            push = in_valid && exp_ready(k);
            pop  = (sz[k] > 0) && out_ready;
            if (!rst) begin
                sz[k]     = 0;
                last_d[k] = '0;
            end else if (flush) begin
                sz[k] = 0;
            end else begin
                if (pop) begin
                    fifo[k][0] = fifo[k][1];
                    sz[k]--;
                end
                if (push) begin
                    fifo[k][sz[k]] = '{c: in_ctrl, d: in_data};
                    sz[k]++;
                end
                if (sz[k] > cap[k]) begin
                    chk($sformatf("s%0d_model_cap", 1 - k), sz[k], cap[k]);
                    sz[k] = cap[k];
                end
            end
            if (sz[k] > 0) last_d[k] = fifo[k][0].d;
        end
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance the model.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] dsave;
        cap[0] = 2;
        cap[1] = 1;
        for (int k = 0; k < 2; k++) begin
            sz[k]     = 0;
            last_d[k] = '0;
        end

        // reset with in_valid high: nothing must be captured
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 12'h123;
        in_data = rnd_data(); out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b1, 12'h321, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b0);

        // streaming at full throughput
        for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b0, 1'b1, CW'(i), rnd_data(), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);

        // stall fills the skid entry, then drains in order
        cyc(1'b1, 1'b0, 1'b1, 12'h0A5, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 12'h05A, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);

        // flush while full, with a simultaneous incoming instruction
        cyc(1'b1, 1'b0, 1'b1, 12'h111, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 12'h222, rnd_data(), 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 12'h3FF, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);

        // bubble: control clears after drain, data stays
        dsave = rnd_data();
        cyc(1'b1, 1'b0, 1'b1, 12'hFFF, dsave, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);
        chk("bubble_data_kept", out_data[0], dsave);
        chk("bubble_ctrl_zero", out_ctrl[0], 12'h000);

        // reset in the middle of a stall discards both entries
        cyc(1'b1, 1'b0, 1'b1, 12'h0C3, rnd_data(), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 12'h03C, rnd_data(), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 12'h0AA, rnd_data(), 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 15) == 0),
                $urandom_range(0, 1) == 1,
                CW'($urandom),
                rnd_data(),
                $urandom_range(0, 3) != 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 12'h000, rnd_data(), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
